// File: rtl/alu_issue_select.sv
// ALU issue/select stage: round-robin picks up to NUM_UNITS ready RS slots per cycle,
// executes them in registered ALU/compare units and broadcasts the results one cycle later.

package alu_issue_pkg;

    // ALU ops use RISC-V funct3 encodings; funct7[5] selects sub / sra.
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SLL  = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b010;
    localparam logic [2:0] ALU_SLTU = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SRL  = 3'b101;
    localparam logic [2:0] ALU_OR   = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b111;

    // Compare ops use the branch funct3 encodings.
    localparam logic [2:0] CMP_BEQ  = 3'b000;
    localparam logic [2:0] CMP_BNE  = 3'b001;
    localparam logic [2:0] CMP_BLT  = 3'b100;
    localparam logic [2:0] CMP_BGE  = 3'b101;
    localparam logic [2:0] CMP_BLTU = 3'b110;
    localparam logic [2:0] CMP_BGEU = 3'b111;

    typedef struct packed {
        logic valid;
    } flush_t;

    typedef struct packed {
        logic [3:0]  tag;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [2:0]  alu_opcode;
        logic [2:0]  cmp_opcode;
        logic [6:0]  funct7;
        logic        valid;
    } rs_t;

    typedef struct packed {
        logic        rdy;
        logic [3:0]  tag;
        logic [31:0] data;
    } sal_t;

endpackage

module alu_issue_exec
    import alu_issue_pkg::*;
(
    input  logic        is_cmp,
    input  logic        alt,
    input  logic [2:0]  alu_opcode,
    input  logic [2:0]  cmp_opcode,
    input  logic [31:0] r1,
    input  logic [31:0] r2,
    output logic [31:0] result
);
    logic [4:0]  shamt;
    logic [31:0] alu_res;
    logic        cmp_hit;

    assign shamt = r2[4:0];

    always_comb begin
        alu_res = '0;
        case (alu_opcode)
            ALU_ADD:  alu_res = alt ? (r1 - r2) : (r1 + r2);
            ALU_SLL:  alu_res = r1 << shamt;
            ALU_SLT:  alu_res = {31'b0, $signed(r1) < $signed(r2)};
            ALU_SLTU: alu_res = {31'b0, r1 < r2};
            ALU_XOR:  alu_res = r1 ^ r2;
            ALU_SRL:  alu_res = alt ? 32'($signed(r1) >>> shamt) : (r1 >> shamt);
            ALU_OR:   alu_res = r1 | r2;
            ALU_AND:  alu_res = r1 & r2;
            default:  alu_res = '0;
        endcase
    end

    always_comb begin
        cmp_hit = 1'b0;
        case (cmp_opcode)
            CMP_BEQ:  cmp_hit = (r1 == r2);
            CMP_BNE:  cmp_hit = (r1 != r2);
            CMP_BLT:  cmp_hit = ($signed(r1) < $signed(r2));
            CMP_BGE:  cmp_hit = ($signed(r1) >= $signed(r2));
            CMP_BLTU: cmp_hit = (r1 < r2);
            CMP_BGEU: cmp_hit = (r1 >= r2);
            default:  cmp_hit = 1'b0;
        endcase
    end

    assign result = is_cmp ? {31'b0, cmp_hit} : alu_res;

endmodule

module alu_issue_select
    import alu_issue_pkg::*;
#(
    parameter int size      = 15,
    parameter int NUM_UNITS = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  flush_t                           flush,
    input  rs_t  [size-1:0]                  rs_data,
    input  logic [size-1:0]                  acu_operation,
    input  logic [size-1:0]                  ready,
    output sal_t [size-1:0]                  broadcast_bus,
    output logic [NUM_UNITS-1:0]             rob_valid,
    output logic [NUM_UNITS-1:0][3:0]        rob_tag,
    output logic [NUM_UNITS-1:0][31:0]       rob_data,
    output logic [size-1:0]                  busy_mask
);
    localparam int PW = $clog2(size);

    logic [PW-1:0]                 rr_ptr;
    logic [PW-1:0]                 rr_next;
    logic [size-1:0]               elig;
    logic [size-1:0]               set_mask;
    logic [size-1:0]               clr_mask;
    logic [NUM_UNITS-1:0]          sel_vld;
    logic [NUM_UNITS-1:0][PW-1:0]  sel_slot;
    logic [NUM_UNITS-1:0][31:0]    sel_res;
    logic [NUM_UNITS-1:0][PW-1:0]  u_slot;
    logic                          unused_f7;

    assign elig = ready & ~busy_mask & {<<{rs_valid_bits()}};

    function automatic logic [size-1:0] rs_valid_bits();
        logic [size-1:0] v;
        for (int i = 0; i < size; i++) v[size-1-i] = rs_data[i].valid;
        return v;
    endfunction

    // Each unit takes the next eligible slot after the ones claimed by lower units.
    always_comb begin : select
        logic [size-1:0] avail;
        logic [PW:0]     sum;
        logic [PW-1:0]   idx;
        logic            taken;
        avail    = elig;
        sum      = '0;
        idx      = '0;
        taken    = 1'b0;
        sel_vld  = '0;
        sel_slot = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            taken = 1'b0;
            for (int k = 0; k < size; k++) begin
                sum = {1'b0, rr_ptr} + (PW+1)'(k);
                idx = (sum >= (PW+1)'(size)) ? PW'(sum - (PW+1)'(size)) : sum[PW-1:0];
                if (!taken && avail[idx]) begin
                    taken       = 1'b1;
                    avail[idx]  = 1'b0;
                    sel_vld[u]  = 1'b1;
                    sel_slot[u] = idx;
                end
            end
        end
    end

    always_comb begin
        rr_next = rr_ptr;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (sel_vld[u])
                rr_next = (sel_slot[u] == PW'(size - 1)) ? '0 : sel_slot[u] + 1'b1;
        end
    end

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (sel_vld[u])   set_mask[sel_slot[u]] = 1'b1;
            if (rob_valid[u]) clr_mask[u_slot[u]]   = 1'b1;
        end
    end

    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
        alu_issue_exec u_exec (
            .is_cmp     (acu_operation[sel_slot[u]]),
            .alt        (rs_data[sel_slot[u]].funct7[5]),
            .alu_opcode (rs_data[sel_slot[u]].alu_opcode),
            .cmp_opcode (rs_data[sel_slot[u]].cmp_opcode),
            .r1         (rs_data[sel_slot[u]].r1),
            .r2         (rs_data[sel_slot[u]].r2),
            .result     (sel_res[u])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rob_valid <= '0;
            rob_tag   <= '0;
            rob_data  <= '0;
            u_slot    <= '0;
            busy_mask <= '0;
            rr_ptr    <= '0;
        end else if (flush.valid) begin
            rob_valid <= '0;
            rob_tag   <= '0;
            rob_data  <= '0;
            u_slot    <= '0;
            busy_mask <= '0;
        end else begin
            rob_valid <= sel_vld;
            for (int u = 0; u < NUM_UNITS; u++) begin
                u_slot[u]   <= sel_vld[u] ? sel_slot[u] : '0;
                rob_tag[u]  <= sel_vld[u] ? rs_data[sel_slot[u]].tag : 4'h0;
                rob_data[u] <= sel_vld[u] ? sel_res[u] : 32'h0;
            end
            // A slot never retires and issues on the same edge: busy blocks eligibility.
            busy_mask <= (busy_mask & ~clr_mask) | set_mask;
            rr_ptr    <= rr_next;
        end
    end

    always_comb begin
        broadcast_bus = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (rob_valid[u])
                broadcast_bus[u_slot[u]] = {1'b1, rob_tag[u], rob_data[u]};
        end
    end

    always_comb begin
        unused_f7 = 1'b0;
        for (int i = 0; i < size; i++)
            unused_f7 = unused_f7 ^ rs_data[i].funct7[6] ^ (^rs_data[i].funct7[4:0]);
    end

endmodule

// File: tb/tb_alu_issue_select.sv
// Directed bench for alu_issue_select: selection order, pointer wrap, ALU/compare
// results, flush and reset behaviour, with hand-computed expectations.
module tb_alu_issue_select;
    import alu_issue_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    flush_t            flush;
    rs_t  [14:0]       rs_data;
    logic [14:0]       acu_operation;
    logic [14:0]       ready;
    sal_t [14:0]       broadcast_bus;
    logic [1:0]        rob_valid;
    logic [1:0][3:0]   rob_tag;
    logic [1:0][31:0]  rob_data;
    logic [14:0]       busy_mask;

    int checks = 0;
    int errors = 0;

    alu_issue_select dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .rs_data       (rs_data),
        .acu_operation (acu_operation),
        .ready         (ready),
        .broadcast_bus (broadcast_bus),
        .rob_valid     (rob_valid),
        .rob_tag       (rob_tag),
        .rob_data      (rob_data),
        .busy_mask     (busy_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [14:0] rdy_mask();
        logic [14:0] m;
        for (int i = 0; i < 15; i++) m[i] = broadcast_bus[i].rdy;
        return m;
    endfunction

    task automatic set_slot(input int i, input logic cmp, input logic [2:0] op, input logic [6:0] f7,
                            input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        rs_data[i] = '{tag: t, r1: a, r2: b, alu_opcode: cmp ? 3'd0 : op,
                       cmp_opcode: cmp ? op : 3'd0, funct7: f7, valid: 1'b1};
        acu_operation[i] = cmp;
        ready[i]         = 1'b1;
    endtask

    task automatic clr_all();
        rs_data       = '0;
        acu_operation = '0;
        ready         = '0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst   = 1'b1;
        flush = '0;
        clr_all();
        step();
        step();
        chk("rst_rob_valid", rob_valid, 2'b00);
        chk("rst_busy", busy_mask, 15'h0);
        chk("rst_bus_rdy", rdy_mask(), 15'h0);
        chk("rst_rob_data", rob_data, 64'h0);
        chk("rst_rob_tag", rob_tag, 8'h0);
        rst = 1'b0;

        // single add on slot 3; slot stays ready but busy blocks re-issue
        set_slot(3, 1'b0, ALU_ADD, 7'h00, 32'd5, 32'd7, 4'h3);
        step();
        chk("add_bus3", broadcast_bus[3], {1'b1, 4'h3, 32'd12});
        chk("add_rdy_mask", rdy_mask(), 15'h0008);
        chk("add_rob_valid", rob_valid, 2'b01);
        chk("add_rob_tag0", rob_tag[0], 4'h3);
        chk("add_rob_data0", rob_data[0], 32'd12);
        chk("add_busy", busy_mask, 15'h0008);
        step();
        chk("noreissue_valid", rob_valid, 2'b00);
        chk("noreissue_rdy", rdy_mask(), 15'h0);
        chk("noreissue_busy", busy_mask, 15'h0);
        clr_all();

        // sub and blt on two units in one cycle (rr_ptr=4, wraps to 0,1)
        set_slot(0, 1'b0, ALU_ADD, 7'h20, 32'd3, 32'd5, 4'h0);
        set_slot(1, 1'b1, CMP_BLT, 7'h00, 32'hFFFF_FFFF, 32'd1, 4'h1);
        step();
        chk("pair_valid", rob_valid, 2'b11);
        chk("sub_data", rob_data[0], 32'hFFFF_FFFE);
        chk("blt_data", rob_data[1], 32'd1);
        chk("blt_tag", rob_tag[1], 4'h1);
        chk("pair_rdy", rdy_mask(), 15'h0003);
        chk("sub_bus0", broadcast_bus[0], {1'b1, 4'h0, 32'hFFFF_FFFE});
        clr_all();
        step();
        chk("pair_idle", rob_valid, 2'b00);

        // reset restarts rr_ptr at 0; slots 2,5 then 9
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_slot(2, 1'b0, ALU_XOR, 7'h00, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'h2);
        set_slot(5, 1'b0, ALU_OR,  7'h00, 32'h0000_00F0, 32'h0000_0F0F, 4'h5);
        set_slot(9, 1'b0, ALU_AND, 7'h00, 32'h1234_5678, 32'h0000_FFFF, 4'h9);
        step();
        chk("rr1_valid", rob_valid, 2'b11);
        chk("rr1_tag0", rob_tag[0], 4'h2);
        chk("rr1_tag1", rob_tag[1], 4'h5);
        chk("xor_data", rob_data[0], 32'h0FF0_0FF0);
        chk("or_data", rob_data[1], 32'h0000_0FFF);
        chk("rr1_busy", busy_mask, 15'h0024);
        ready[2] = 1'b0; rs_data[2].valid = 1'b0;
        ready[5] = 1'b0; rs_data[5].valid = 1'b0;
        step();
        chk("rr2_valid", rob_valid, 2'b01);
        chk("rr2_tag0", rob_tag[0], 4'h9);
        chk("and_data", rob_data[0], 32'h0000_5678);
        chk("rr2_rdy", rdy_mask(), 15'h0200);
        clr_all();
        step();
        chk("rr_idle", rob_valid, 2'b00);

        // advance rr_ptr to 14 with an sll on slot 13
        set_slot(13, 1'b0, ALU_SLL, 7'h00, 32'd1, 32'h24, 4'hD);
        step();
        chk("sll_data", rob_data[0], 32'd16);
        clr_all();
        step();

        // wrap: 14 then (slot 0 ready but invalid) then 1
        set_slot(14, 1'b1, CMP_BGE, 7'h00, 32'd5, 32'd5, 4'hE);
        set_slot(1,  1'b1, CMP_BNE, 7'h00, 32'd5, 32'd5, 4'h1);
        ready[0] = 1'b1;
        step();
        chk("wrap_valid", rob_valid, 2'b11);
        chk("wrap_tag0", rob_tag[0], 4'hE);
        chk("wrap_tag1", rob_tag[1], 4'h1);
        chk("bge_data", rob_data[0], 32'd1);
        chk("bne_data", rob_data[1], 32'd0);
        chk("wrap_rdy", rdy_mask(), 15'h4002);
        clr_all();
        step();

        // rr_ptr is now 2: slot 1 must be passed over in favour of 2 and 3
        set_slot(1, 1'b0, ALU_ADD, 7'h00, 32'd1, 32'd1, 4'h1);
        set_slot(2, 1'b0, ALU_SRL, 7'h20, 32'h8000_0000, 32'd4, 4'h2);
        set_slot(3, 1'b0, ALU_SRL, 7'h00, 32'h8000_0000, 32'd4, 4'h3);
        step();
        chk("ptr2_tag0", rob_tag[0], 4'h2);
        chk("sra_data", rob_data[0], 32'hF800_0000);
        chk("ptr2_tag1", rob_tag[1], 4'h3);
        chk("srl_data", rob_data[1], 32'h0800_0000);
        clr_all();
        step();

        // flush the cycle after slot 4 issues, while slot 6 is ready
        set_slot(4, 1'b0, ALU_ADD, 7'h00, 32'd10, 32'd20, 4'h4);
        step();
        clr_all();
        set_slot(6, 1'b1, CMP_BLTU, 7'h00, 32'd1, 32'hFFFF_FFFF, 4'h6);
        flush.valid = 1'b1;
        chk("flushcyc_rdy", rdy_mask(), 15'h0010);
        chk("flushcyc_data", rob_data[0], 32'd30);
        step();
        flush.valid = 1'b0;
        chk("postflush_valid", rob_valid, 2'b00);
        chk("postflush_rdy", rdy_mask(), 15'h0);
        chk("postflush_busy", busy_mask, 15'h0);
        set_slot(2, 1'b1, CMP_BGEU, 7'h00, 32'd3, 32'd3, 4'h2);
        step();
        chk("keepptr_tag0", rob_tag[0], 4'h6);
        chk("bltu_data", rob_data[0], 32'd1);
        chk("keepptr_tag1", rob_tag[1], 4'h2);
        chk("bgeu_data", rob_data[1], 32'd1);
        clr_all();
        step();

        // reset while a result is in flight and new slots are ready
        set_slot(7, 1'b0, ALU_ADD, 7'h00, 32'd1, 32'd2, 4'h7);
        step();
        clr_all();
        set_slot(8,  1'b0, ALU_ADD, 7'h00, 32'd100, 32'd1, 4'h8);
        set_slot(10, 1'b1, CMP_BEQ, 7'h00, 32'd7, 32'd7, 4'hA);
        ready[0] = 1'b1;
        rst = 1'b1;
        step();
        chk("midrst_valid", rob_valid, 2'b00);
        chk("midrst_rdy", rdy_mask(), 15'h0);
        chk("midrst_busy", busy_mask, 15'h0);
        chk("midrst_data", rob_data, 64'h0);
        rst = 1'b0;
        step();
        chk("after_rst_tag0", rob_tag[0], 4'h8);
        chk("after_rst_data0", rob_data[0], 32'd101);
        chk("after_rst_tag1", rob_tag[1], 4'hA);
        chk("beq_data", rob_data[1], 32'd1);
        clr_all();
        step();
        chk("final_idle", rob_valid, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_select.md
Name: alu_issue_select

Overview:
- Sits directly downstream of the ALU reservation station.
- Each cycle it picks up to NUM_UNITS ready RS entries round-robin and executes them in registered ALU/compare units.
- Results are driven on the per-slot broadcast bus: the RS frees the slot, and the ROB captures the tag/data.
- It stops a slot from re-issuing while that slot's result is still in flight.

Parameters:
- size, 15, number of RS slots (must equal the RS size).
- NUM_UNITS, 2, parallel execute units; selections per cycle.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  flush_t  only .valid is used here.
- rs_data  in  rs_t[size]  RS entries: tag, r1, r2, alu_opcode, cmp_opcode, funct7, valid.
- acu_operation  in  1[size]  1 = compare op, 0 = ALU op.
- ready  in  size  per-slot operands-resolved flag.
- broadcast_bus  out  sal_t[size]  per-slot result.
  - .rdy is a one-cycle pulse.
  - .tag and .data carry the result.
- rob_valid  out  NUM_UNITS  a unit's result is valid this cycle.
- rob_tag  out  4[NUM_UNITS]  ROB tag of that result.
- rob_data  out  32[NUM_UNITS]  result value.
- busy_mask  out  size  slots issued and awaiting broadcast (debug/verification).

Behaviour:
- Reset: every broadcast_bus entry is all zero; rob_valid=0; rob_tag=0; rob_data=0; busy_mask=0; rr_ptr=0.
- Eligibility: slot i is eligible iff ready[i] & rs_data[i].valid & ~busy_mask[i].
- Selection (combinational, cycle N):
  - Scan from rr_ptr upward, wrapping modulo size.
  - Take the first NUM_UNITS eligible slots, in order, and assign them to unit 0, 1, ...
- Issue edge (end of cycle N):
  - Each unit registers slot index, tag, and the computed result.
  - busy bits are set for the issued slots.
  - rr_ptr becomes (last issued slot + 1) mod size; it is unchanged if nothing issued.
- Result (cycle N+1):
  - broadcast_bus[slot].rdy=1 with tag and data.
  - rob_valid[u]=1, plus rob_tag and rob_data.
  - All of these are zero or deasserted in the following cycle unless a new issue occurs.
- Busy clear: at the end of N+1 the busy bit clears. The RS clears the slot on that same edge, so ready is low from N+2 and no double issue occurs.
- Latency: fixed at 1 cycle from the ready observation to the broadcast.
- Throughput: NUM_UNITS results per cycle. A slot can re-issue at the earliest 2 cycles after its previous issue.
- ALU ops, when acu_operation=0 (32-bit, wrap-around arithmetic):
  - add: r1+r2, or r1-r2 when funct7[5]=1.
  - sll: r1 << r2[4:0].
  - xor, or, and: bitwise.
  - srl: logical shift by r2[4:0].
  - sra: arithmetic shift by r2[4:0].
- Compare ops, when acu_operation=1:
  - beq, bne, blt, bge, bltu, bgeu evaluated on r1 and r2.
  - The result is zero-extended to 32 bits (1 or 0). It serves both branches and slt/sltu.
- Flush: when flush.valid is high at an edge:
  - All unit result registers are invalidated, so nothing is broadcast in the next cycle.
  - busy_mask is cleared.
  - Nothing is issued on that edge.
  - rr_ptr is retained.
  - Results being driven during the flush cycle itself still complete normally.
- Reset mid-operation takes priority over flush and issue; in-flight results are dropped.
- Fewer eligible slots than NUM_UNITS: the unused units produce rob_valid=0.
- No eligible slots: the registers hold their invalid state and rr_ptr holds.
- Slot with valid=0 but ready=1 is never issued.
- Only the slot index owned by a unit is driven on broadcast_bus. Two units can never target the same slot.

Test Plan:
- Slot 3 ready with add, r1=5, r2=7 -> next cycle broadcast_bus[3].rdy=1, data=12, tag matches, rob_valid[0]=1; slot 3 is not re-issued in that cycle.
- Slot 0 sub (funct7=0x20), r1=3, r2=5 -> data=0xFFFFFFFE. Slot 1 cmp_blt, r1=-1, r2=1 -> data=1. Both appear in the same cycle, on units 0 and 1.
- Slots 2, 5, 9 ready with rr_ptr=0 -> cycle 1 broadcasts slots 2 and 5, rr_ptr=6; slot 9 broadcasts in cycle 2.
- Wrap: rr_ptr=14, slots 14 and 1 ready -> both issue; rr_ptr=2.
- sra, r1=0x80000000, r2=4 -> 0xF8000000. srl with the same operands -> 0x08000000.
- flush.valid asserted in the cycle after issue of slot 4, while slot 6 is ready -> slot 4 broadcast completes, slot 6 is not issued on the flush edge, and no broadcast occurs the following cycle.
- rst asserted mid-issue -> all outputs are zero the next cycle and busy_mask=0.
